// File: rtl/softmax_stream.sv
// softmax_stream: buffers one vector of signed coefficients and computes
// base-2 exponents and their saturating sum. It then emits one Q1.OUT_FRAC
// alpha per element, using a bit-serial restoring divider.
module softmax_stream #(
    parameter int DATA_W    = 16,
    parameter int MAX_NODES = 16,
    parameter int EXP_W     = 16,
    parameter int SUM_W     = EXP_W + $clog2(MAX_NODES),
    parameter int OUT_FRAC  = 8,
    parameter int MAX_SUB   = 1,
    localparam int Q_W      = OUT_FRAC + 1,
    localparam int CNT_W    = $clog2(MAX_NODES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [Q_W-1:0]    out_data,
    output logic              out_last,
    output logic [CNT_W-1:0]  out_count,
    output logic              ovf_o
);

    localparam int IDX_W = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
    localparam int BUF_W = (DATA_W > EXP_W) ? DATA_W : EXP_W;
    localparam int DIV_W = $clog2(Q_W + 1);
    localparam logic [EXP_W-1:0] E_TOP = {1'b1, {(EXP_W-1){1'b0}}};

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_EXP  = 3'd2;
    localparam logic [2:0] S_DIV  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    logic [2:0]               state, state_nxt;
    logic [BUF_W-1:0]         buf_mem [MAX_NODES];
    logic [CNT_W-1:0]         count, idx, cnt_eff;
    logic signed [DATA_W-1:0] max_r;
    logic [SUM_W-1:0]         sum, sum_sat;
    logic [SUM_W:0]           sum_add;
    logic [SUM_W-1:0]         rem, rem_new;
    logic [SUM_W:0]           rem_sh;
    logic [Q_W-2:0]           quo;
    logic [Q_W-1:0]           q_shift, q_fin;
    logic [DIV_W-1:0]         div_cnt;
    logic                     sat_r, sat_now, sat_eff, q_bit;
    logic                     xfer, beat_end, idx_last;
    logic [BUF_W-1:0]         rd;
    logic signed [DATA_W-1:0] coef;
    logic signed [DATA_W:0]   coef_x, diff;
    logic [EXP_W-1:0]         e_val, e_rd;

    // Handshake decode. A vector ends on in_last or on the beat that fills the buffer.
    // From IDLE the beat is always element 0, whatever count still holds.
    always_comb begin
        xfer     = in_valid & in_ready;
        cnt_eff  = (state == S_LOAD) ? count : '0;
        beat_end = in_last || (cnt_eff == CNT_W'(MAX_NODES - 1));
        idx_last = (idx == count - CNT_W'(1));
        rd       = buf_mem[idx[IDX_W-1:0]];
        coef     = $signed(rd[DATA_W-1:0]);
        e_rd     = rd[EXP_W-1:0];
    end

    // Base-2 exponent of the element at idx, and the saturating running sum.
    always_comb begin
        coef_x = {coef[DATA_W-1], coef};
        diff   = {max_r[DATA_W-1], max_r} - coef_x;
        e_val  = '0;
        if (MAX_SUB != 0) begin
            // diff is never negative because max_r bounds every coefficient
            if ($unsigned(diff) >= (DATA_W+1)'(EXP_W))
                e_val = '0;
            else
                e_val = E_TOP >> $unsigned(diff);
        end else begin
            if (coef_x[DATA_W] || (coef_x == '0))
                e_val = EXP_W'(1);
            else if ($unsigned(coef_x) >= (DATA_W+1)'(EXP_W - 1))
                e_val = E_TOP;
            else
                e_val = EXP_W'(1) << $unsigned(coef_x);
        end
        sum_add = {1'b0, sum} + (SUM_W+1)'(e_val);
        sum_sat = sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
    end

    // One restoring-division step. The quotient always fits Q_W bits unless
    // e>>1 >= sum. So the partial remainder starts at e>>1, and shifting in
    // e[0] makes the first shifted value e itself. Zeros follow from OUT_FRAC.
    always_comb begin
        rem_sh  = (div_cnt == '0) ? (SUM_W+1)'(e_rd) : {rem, 1'b0};
        q_bit   = (rem_sh >= {1'b0, sum});
        rem_new = q_bit ? SUM_W'(rem_sh - {1'b0, sum}) : rem_sh[SUM_W-1:0];
        sat_now = ((SUM_W+1)'(e_rd >> 1) >= {1'b0, sum});
        sat_eff = (div_cnt == '0) ? sat_now : sat_r;
        q_shift = {quo, q_bit};
        q_fin   = sat_eff ? '1 : q_shift;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (xfer) state_nxt = beat_end ? S_EXP : S_LOAD;
            S_LOAD:  if (xfer && beat_end) state_nxt = S_EXP;
            S_EXP:   if (idx_last) state_nxt = S_DIV;
            S_DIV:   if (div_cnt == DIV_W'(Q_W - 1)) state_nxt = S_OUT;
            S_OUT:   if (out_ready) state_nxt = out_last ? (in_valid ? S_LOAD : S_IDLE) : S_DIV;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Element buffer. It holds coefficients while loading, and EXP overwrites each entry with its exponent.
    always_ff @(posedge clk) begin
        if (xfer)
            buf_mem[cnt_eff[IDX_W-1:0]] <= BUF_W'($signed(in_data));
        else if (state == S_EXP)
            buf_mem[idx[IDX_W-1:0]] <= BUF_W'(e_val);
    end

    // Control, accumulation, divider and registered output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            count     <= '0;
            idx       <= '0;
            max_r     <= '0;
            sum       <= '0;
            rem       <= '0;
            quo       <= '0;
            div_cnt   <= '0;
            sat_r     <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_count <= '0;
            ovf_o     <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == S_IDLE) || (state_nxt == S_LOAD);
            ovf_o    <= 1'b0;
            case (state)
                S_IDLE, S_LOAD: begin
                    if (xfer) begin
                        count <= cnt_eff + CNT_W'(1);
                        if ((cnt_eff == '0) || ($signed(in_data) > max_r))
                            max_r <= $signed(in_data);
                        if (beat_end) begin
                            ovf_o <= !in_last;
                            sum   <= '0;
                            idx   <= '0;
                        end
                    end
                end
                S_EXP: begin
                    sum <= sum_sat;
                    if (idx_last) begin
                        idx     <= '0;
                        div_cnt <= '0;
                    end else begin
                        idx <= idx + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    rem <= rem_new;
                    quo <= q_shift[Q_W-2:0];
                    if (div_cnt == '0)
                        sat_r <= sat_now;
                    if (div_cnt == DIV_W'(Q_W - 1)) begin
                        out_valid <= 1'b1;
                        out_data  <= q_fin;
                        out_last  <= idx_last;
                        out_count <= count;
                        div_cnt   <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            // A waiting beat is taken in LOAD as element 0 of the next vector
                            if (in_valid) begin
                                count <= '0;
                                max_r <= '0;
                            end
                        end else begin
                            idx <= idx + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_stream.sv
// tb_softmax_stream: drives one input stream into two instances, one per exponent
// mode. Alphas are checked against an arithmetic softmax model, with spec
// constants used where the vectors are fixed.
module tb_softmax_stream;

    localparam int DATA_W    = 16;
    localparam int MAX_NODES = 8;
    localparam int EXP_W     = 16;
    localparam int OUT_FRAC  = 8;
    localparam int Q_W       = OUT_FRAC + 1;
    localparam int CNT_W     = $clog2(MAX_NODES + 1);
    localparam int SUM_MAX   = (1 << (EXP_W + $clog2(MAX_NODES))) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] in_data = '0;

    logic             in_ready1, out_valid1, out_last1, ovf1;
    logic [Q_W-1:0]   out_data1;
    logic [CNT_W-1:0] out_count1;
    logic             in_ready0, out_valid0, out_last0, ovf0;
    logic [Q_W-1:0]   out_data0;
    logic [CNT_W-1:0] out_count0;

    softmax_stream #(.DATA_W(DATA_W), .MAX_NODES(MAX_NODES), .EXP_W(EXP_W),
                     .OUT_FRAC(OUT_FRAC), .MAX_SUB(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .out_last(out_last1),
        .out_count(out_count1), .ovf_o(ovf1));

    softmax_stream #(.DATA_W(DATA_W), .MAX_NODES(MAX_NODES), .EXP_W(EXP_W),
                     .OUT_FRAC(OUT_FRAC), .MAX_SUB(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_last(out_last0),
        .out_count(out_count0), .ovf_o(ovf0));

    always #5 clk = ~clk;

    // Cycle index: inputs and outputs sampled at a negedge belong to cycle 'cyc'
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;
    int last_xfer = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Softmax reference: exponent from the mode rule, saturating sum, floor divide, clamp
    function automatic int exp_of(input int c, input int mx, input bit maxsub);
        int d;
        if (maxsub) begin
            d = mx - c;
            if (d >= EXP_W) return 0;
            return (1 << (EXP_W - 1)) / (1 << d);
        end
        if (c <= 0) return 1;
        if (c >= EXP_W - 1) return 1 << (EXP_W - 1);
        return 2 ** c;
    endfunction

    function automatic void model(input int v[$], input bit maxsub, output int a[$]);
        int     mx;
        longint s;
        longint q;
        int     e[$];
        mx = v[0];
        s  = 0;
        foreach (v[k]) if (v[k] > mx) mx = v[k];
        foreach (v[k]) begin
            e.push_back(exp_of(v[k], mx, maxsub));
            s = s + e[k];
        end
        if (s > SUM_MAX) s = SUM_MAX;
        a = {};
        foreach (e[k]) begin
            q = (longint'(e[k]) * (1 << OUT_FRAC)) / s;
            a.push_back((q > (1 << Q_W) - 1) ? (1 << Q_W) - 1 : int'(q));
        end
    endfunction

    // Offer each beat until accepted; check ovf_o and in_ready on the cycle after each transfer
    task automatic send_vec(input int v[$], input bit use_last);
        for (int k = 0; k < v.size(); k++) begin
            int w;
            bit ended;
            in_valid = 1'b1;
            in_data  = DATA_W'(v[k]);
            in_last  = use_last && (k == v.size() - 1);
            w = 0;
            while (!in_ready1 && w < 400) begin
                @(negedge clk);
                w++;
            end
            chk("in_ready1 accept", in_ready1, 1);
            chk("in_ready0 accept", in_ready0, 1);
            last_xfer = cyc;
            @(negedge clk);
            ended = (k == v.size() - 1);
            chk("ovf_o mode1", ovf1, ended && !use_last);
            chk("ovf_o mode0", ovf0, ended && !use_last);
            chk("in_ready after beat", in_ready1, !ended);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Collect one vector of alphas. Optionally randomise out_ready and offer the next vector's first beat.
    task automatic recv_vec(input int a1[$], input int a0[$], input bit rnd,
                            input bit nxt, input int nxt_data, input bit nxt_last);
        int n;
        int hs;
        n  = a1.size();
        hs = 0;
        if (!rnd) out_ready = 1'b1;
        for (int j = 0; j < n; j++) begin
            int w;
            w = 0;
            while (!out_valid1 && w < 400) begin
                @(negedge clk);
                w++;
                if (rnd) out_ready = 1'($urandom_range(0, 1));
            end
            chk("out_valid1", out_valid1, 1);
            chk("out_valid0", out_valid0, 1);
            if (!rnd) begin
                if (j == 0) chk("first alpha latency", cyc - last_xfer, n + Q_W + 1);
                else        chk("alpha spacing", cyc - hs, Q_W + 1);
            end
            chk("alpha mode1", out_data1, a1[j]);
            chk("alpha mode0", out_data0, a0[j]);
            chk("out_last", out_last1, j == n - 1);
            chk("out_count", out_count1, n);
            chk("out_count mode0", out_count0, n);
            if (j == n - 1 && nxt) begin
                in_valid = 1'b1;
                in_data  = DATA_W'(nxt_data);
                in_last  = nxt_last;
            end
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            w = 0;
            while (!out_ready) begin
                @(negedge clk);
                w++;
                chk("stall valid", out_valid1, 1);
                chk("stall data mode1", out_data1, a1[j]);
                chk("stall data mode0", out_data0, a0[j]);
                chk("stall last", out_last1, j == n - 1);
                chk("stall count", out_count1, n);
                out_ready = (w >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            hs = cyc;
            @(negedge clk);
            chk("valid drops after handshake", out_valid1, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int v[$];
        int nv[$];
        int a1[$];
        int a0[$];
        int rvals[6][8];
        int rlen[6];
        int w;
        bit seen;

        // Reset state
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset in_ready", in_ready1, 0);
        chk("reset out_valid", out_valid1, 0);
        chk("reset out_data", out_data1, 0);
        chk("reset out_last", out_last1, 0);
        chk("reset out_count", out_count1, 0);
        chk("reset ovf_o", ovf1, 0);
        chk("reset in_ready mode0", in_ready0, 0);
        rst_n = 1'b1;
        chk("in_ready at release", in_ready1, 0);
        @(negedge clk);
        chk("in_ready after release", in_ready1, 1);

        // Fixed vectors with known alphas
        v = {2, 1, 0, 0};
        a1 = {128, 64, 32, 32};
        model(v, 1'b0, a0);
        send_vec(v, 1'b1);
        recv_vec(a1, a0, 1'b0, 1'b0, 0, 1'b0);

        v = {-5};
        a1 = {256};
        model(v, 1'b0, a0);
        send_vec(v, 1'b1);
        recv_vec(a1, a0, 1'b0, 1'b0, 0, 1'b0);

        v = {0, 1};
        a0 = {85, 170};
        model(v, 1'b1, a1);
        send_vec(v, 1'b1);
        recv_vec(a1, a0, 1'b0, 1'b0, 0, 1'b0);

        v = {40, 0};
        a1 = {256, 0};
        model(v, 1'b0, a0);
        send_vec(v, 1'b1);
        recv_vec(a1, a0, 1'b0, 1'b0, 0, 1'b0);

        // Truncation: MAX_NODES beats, none marked last
        v = {};
        for (int k = 0; k < MAX_NODES; k++) v.push_back(int'($urandom_range(0, 40)) - 15);
        model(v, 1'b1, a1);
        model(v, 1'b0, a0);
        send_vec(v, 1'b0);
        recv_vec(a1, a0, 1'b0, 1'b0, 0, 1'b0);

        // Random vectors, random out_ready, each next vector offered on the final alpha
        for (int k = 0; k < 6; k++) begin
            rlen[k] = int'($urandom_range(1, MAX_NODES));
            for (int m = 0; m < MAX_NODES; m++) rvals[k][m] = int'($urandom_range(0, 50)) - 20;
        end
        v = {};
        for (int m = 0; m < rlen[0]; m++) v.push_back(rvals[0][m]);
        send_vec(v, 1'b1);
        for (int k = 0; k < 6; k++) begin
            model(v, 1'b1, a1);
            model(v, 1'b0, a0);
            nv = {};
            if (k < 5) for (int m = 0; m < rlen[k+1]; m++) nv.push_back(rvals[k+1][m]);
            if (k < 5) recv_vec(a1, a0, 1'b1, 1'b1, nv[0], nv.size() == 1);
            else       recv_vec(a1, a0, 1'b1, 1'b0, 0, 1'b0);
            v = nv;
            if (k < 5) send_vec(v, 1'b1);
        end

        // Reset during DIV of the second element abandons the vector
        v = {3, -2, 7};
        model(v, 1'b1, a1);
        out_ready = 1'b0;
        send_vec(v, 1'b1);
        w = 0;
        while (!out_valid1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("pre-reset alpha", out_data1, a1[0]);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("pre-reset count", out_count1, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid reset out_valid", out_valid1, 0);
        chk("mid reset out_data", out_data1, 0);
        chk("mid reset out_data mode0", out_data0, 0);
        chk("mid reset out_count", out_count1, 0);
        chk("mid reset out_last", out_last1, 0);
        chk("mid reset ovf_o", ovf1, 0);
        chk("mid reset in_ready", in_ready1, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("in_ready at re-release", in_ready1, 0);
        @(negedge clk);
        chk("in_ready after re-release", in_ready1, 1);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid1 || out_valid0) seen = 1'b1;
        end
        chk("abandoned vector silent", seen, 0);

        v = {6, 6, -1};
        model(v, 1'b1, a1);
        model(v, 1'b0, a0);
        out_ready = 1'b1;
        send_vec(v, 1'b1);
        recv_vec(a1, a0, 1'b0, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
